// File: rtl/systolic_feed_sequencer.sv
// systolic_feed_sequencer
//   Source-side driver for a 1xK systolic MAC chain. Each start runs one tile:
//   clear the accumulators, preload K weights, stream N activation vectors, drain
//   the chain, then pulse done. The FSM runs IDLE -> CLEAR -> LOAD_W -> STREAM -> DRAIN -> DONE.
//   Every PE_* output is a register, so the effect of a cycle's state or handshake
//   shows on PE_* in the following cycle.
//
//   Optional feature: define SYSTOLIC_FEED_SKEW_EN to delay lane k by k advance cycles
//   inside this block (DRAIN then lasts ACCU_NUM-1 cycles). Without it, lanes are
//   driven unskewed and DRAIN is skipped.
//
// Ports
//   clk, reset_n              clock, synchronous active-low reset
//   start                     tile start pulse, sampled only in IDLE
//   busy, done                tile in progress / 1-cycle completion pulse
//   wet_valid/ready/data      weight stream (signed BW_WET)
//   act_valid/ready/data      activation-vector stream (ACCU_NUM signed BW_ACT lanes)
//   PE_mac_enable             chain advance enable
//   PE_clear_acc              accumulator clear
//   PE_weight_partial_sel     1 = weight on the above-input, 0 = partial sum
//   PE_wet_in                 weight / partial-sum seed into PE 0
//   PE_act_in                 per-lane activations, lane k feeds PE k
module systolic_feed_sequencer #(
    parameter int unsigned ACCU_NUM = 5,
    parameter int unsigned BN_NUM   = 10,
    parameter int unsigned BW_ACT   = 8,
    parameter int unsigned BW_WET   = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    input  logic                     wet_valid,
    output logic                     wet_ready,
    input  logic signed [BW_WET-1:0] wet_data,
    input  logic                     act_valid,
    output logic                     act_ready,
    input  logic signed [BW_ACT-1:0] act_data [ACCU_NUM],
    output logic                     PE_mac_enable,
    output logic                     PE_clear_acc,
    output logic                     PE_weight_partial_sel,
    output logic signed [BW_WET-1:0] PE_wet_in,
    output logic signed [BW_ACT-1:0] PE_act_in [ACCU_NUM]
);

`ifdef SYSTOLIC_FEED_SKEW_EN
    localparam int unsigned DrainLen = ACCU_NUM - 1;
`else
    localparam int unsigned DrainLen = 0;
`endif

    localparam int unsigned WcntW = $clog2(ACCU_NUM + 1);
    localparam int unsigned AcntW = $clog2(BN_NUM + 1);
    localparam int unsigned DcntW = (ACCU_NUM > 2) ? $clog2(ACCU_NUM) : 1;

    localparam logic [WcntW-1:0] WLast = WcntW'(ACCU_NUM - 1);
    localparam logic [AcntW-1:0] ALast = AcntW'(BN_NUM - 1);
    localparam logic [DcntW-1:0] DLast = DcntW'((DrainLen > 0) ? DrainLen - 1 : 0);

    typedef enum logic [2:0] {StIdle, StClear, StLoadW, StStream, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [WcntW-1:0] wcnt_q, wcnt_d;
    logic [AcntW-1:0] acnt_q, acnt_d;
    logic [DcntW-1:0] dcnt_q, dcnt_d;

    logic                     mac_q, clr_q, sel_q;
    logic signed [BW_WET-1:0] wet_q;

    logic wet_fire, act_fire, drain_adv, advance;

    // Readies decode the state only, never the valids.
    assign wet_ready = (state_q == StLoadW);
    assign act_ready = (state_q == StStream);
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign done      = (state_q == StDone);

    assign wet_fire  = wet_ready && wet_valid;
    assign act_fire  = act_ready && act_valid;
    assign drain_adv = (state_q == StDrain);
    assign advance   = act_fire || drain_adv;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        acnt_d  = acnt_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StClear;
            StClear: state_d = StLoadW;
            StLoadW: begin
                if (wet_valid) begin
                    if (wcnt_q == WLast) begin
                        wcnt_d  = '0;
                        state_d = StStream;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            StStream: begin
                if (act_valid) begin
                    if (acnt_q == ALast) begin
                        acnt_d  = '0;
                        // With no drain needed the tile finishes straight from STREAM.
                        state_d = (DrainLen == 0) ? StDone : StDrain;
                    end else begin
                        acnt_d = acnt_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (dcnt_q == DLast) begin
                    dcnt_d  = '0;
                    state_d = StDone;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIdle;
            wcnt_q  <= '0;
            acnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            acnt_q  <= acnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    // Control/weight outputs; on bubbles only mac_enable drops, the rest holds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mac_q <= 1'b0;
            clr_q <= 1'b0;
            sel_q <= 1'b0;
            wet_q <= '0;
        end else begin
            mac_q <= wet_fire || advance;
            clr_q <= (state_q == StClear);
            if (wet_fire) begin
                sel_q <= 1'b1;
                wet_q <= wet_data;
            end else if (advance) begin
                sel_q <= 1'b0;
                wet_q <= '0;
            end
        end
    end

    assign PE_mac_enable         = mac_q;
    assign PE_clear_acc          = clr_q;
    assign PE_weight_partial_sel = sel_q;
    assign PE_wet_in             = wet_q;

`ifdef SYSTOLIC_FEED_SKEW_EN
    // Lane k passes through k shift stages that move only on advance cycles,
    // so bubbles never bend the diagonal wavefront.
    for (genvar k = 0; k < ACCU_NUM; k++) begin : g_lane
        logic signed [BW_ACT-1:0] lane_in;
        logic signed [BW_ACT-1:0] lane_q;

        assign lane_in = act_fire ? act_data[k] : '0;

        if (k == 0) begin : g_direct
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    lane_q <= '0;
                end else if (advance) begin
                    lane_q <= lane_in;
                end
            end
        end else begin : g_delay
            logic signed [BW_ACT-1:0] sr_q [k];
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    for (int j = 0; j < k; j++) sr_q[j] <= '0;
                    lane_q <= '0;
                end else if (advance) begin
                    sr_q[0] <= lane_in;
                    for (int j = 1; j < k; j++) sr_q[j] <= sr_q[j-1];
                    lane_q <= sr_q[k-1];
                end
            end
        end

        assign PE_act_in[k] = lane_q;
    end
`else
    logic signed [BW_ACT-1:0] lane_q [ACCU_NUM];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < ACCU_NUM; k++) lane_q[k] <= '0;
        end else if (advance) begin
            for (int k = 0; k < ACCU_NUM; k++) lane_q[k] <= act_fire ? act_data[k] : '0;
        end
    end

    assign PE_act_in = lane_q;
`endif

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Bench for systolic_feed_sequencer (ACCU_NUM=5, BN_NUM=10). Each tile is described as a
// timeline of events (start, clear, weight beats, bubbles, vector beats, drain, done);
// the expected handshake/status per cycle and the PE outputs one cycle later follow from it.
module tb_systolic_feed_sequencer;
    localparam int K  = 5;
    localparam int N  = 10;
    localparam int BA = 8;
    localparam int BW = 8;
`ifdef SYSTOLIC_FEED_SKEW_EN
    localparam int D    = K - 1;
    localparam int SKEW = 1;
`else
    localparam int D    = 0;
    localparam int SKEW = 0;
`endif

    logic clk = 1'b0;
    logic reset_n, start, wet_valid, act_valid;
    logic signed [BW-1:0] wet_data;
    logic signed [BA-1:0] act_data [K];
    logic busy, done, wet_ready, act_ready, mac, clr, sel;
    logic signed [BW-1:0] pe_wet;
    logic signed [BA-1:0] pe_act [K];

    systolic_feed_sequencer #(.ACCU_NUM(K), .BN_NUM(N), .BW_ACT(BA), .BW_WET(BW)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
        .wet_valid(wet_valid), .wet_ready(wet_ready), .wet_data(wet_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .PE_mac_enable(mac), .PE_clear_acc(clr), .PE_weight_partial_sel(sel),
        .PE_wet_in(pe_wet), .PE_act_in(pe_act)
    );

    always #5 clk = ~clk;

    typedef enum int {EvStart, EvClear, EvBubW, EvW, EvBubA, EvA, EvDrain, EvDone, EvIdle} ev_e;
    typedef struct {ev_e kind; int idx;} ev_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Tile data and gap schedule
    logic signed [BW-1:0] wts [K];
    logic signed [BA-1:0] vec [N][K];
    int wgap [K];
    int agap [N];

    // Expected PE output state
    logic m_mac, m_clr, m_sel;
    logic signed [BW-1:0] m_wet;
    logic signed [BA-1:0] m_lane [K];

    // Observations from the last tile
    int obs_done_cnt, obs_done_cyc, obs_load_off, obs_adv;
    int obs_first_one [K];
    logic signed [BW-1:0] obs_wet_q [$];
    logic signed [BA-1:0] obs_last_lane, obs_lane0_first;

    // Lane k on advance n carries vector n-k (skewed) or vector n (unskewed), else zero.
    function automatic logic signed [BA-1:0] lane_val(int n, int k);
        int j;
        j = n - ((SKEW != 0) ? k : 0);
        if (j >= 0 && j < N) return vec[j][k];
        return '0;
    endfunction

    task automatic model_reset();
        m_mac = 1'b0; m_clr = 1'b0; m_sel = 1'b0; m_wet = '0;
        for (int k = 0; k < K; k++) m_lane[k] = '0;
    endtask

    task automatic gen_data(input int mode);
        for (int k = 0; k < K; k++) begin
            wts[k]  = (mode == 1) ? BW'(k + 1) : BW'($urandom);
            wgap[k] = 0;
        end
        for (int i = 0; i < N; i++) begin
            agap[i] = 0;
            for (int k = 0; k < K; k++) begin
                if (mode == 1) vec[i][k] = BA'(i + 1);
                else if (mode == 2) begin
                    case ($urandom_range(0, 2))
                        0:       vec[i][k] = -8'sd128;
                        1:       vec[i][k] = 8'sd127;
                        default: vec[i][k] = BA'($urandom);
                    endcase
                end else vec[i][k] = BA'($urandom);
            end
        end
        if (mode == 2) begin
            vec[0][0] = -8'sd128;
            vec[0][1] = 8'sd127;
        end
    endtask

    // Runs one tile timeline, checking every cycle. abort_idx >= 0 pulls reset_n low
    // during that STREAM beat and stops the timeline there.
    task automatic drive_tile(input bit hold_start, input int abort_idx);
        ev_t evq [$];
        ev_t e;
        int widx, aidx;
        bit eb, ed, ewr, ear;
        evq.push_back('{EvStart, 0});
        evq.push_back('{EvClear, 0});
        for (int i = 0; i < K; i++) begin
            for (int g = 0; g < wgap[i]; g++) evq.push_back('{EvBubW, i});
            evq.push_back('{EvW, i});
        end
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < agap[i]; g++) evq.push_back('{EvBubA, i});
            evq.push_back('{EvA, i});
        end
        for (int d = 0; d < D; d++) evq.push_back('{EvDrain, N + d});
        evq.push_back('{EvDone, 0});
        evq.push_back('{EvIdle, 0});
        evq.push_back('{EvIdle, 0});

        obs_done_cnt = 0; obs_done_cyc = -1; obs_load_off = 0; obs_adv = 0;
        obs_wet_q.delete();
        obs_last_lane = '0; obs_lane0_first = '0;
        for (int k = 0; k < K; k++) obs_first_one[k] = -1;
        widx = 0; aidx = 0;

        for (int c = 0; c < evq.size(); c++) begin
            e = evq[c];
            start     = (e.kind == EvStart) || (hold_start && e.kind != EvIdle);
            wet_valid = (e.kind != EvBubW);
            act_valid = (e.kind != EvBubA);
            wet_data  = wts[(widx < K) ? widx : K - 1];
            for (int k = 0; k < K; k++)
                act_data[k] = (e.kind == EvBubA) ? BA'($urandom) : vec[(aidx < N) ? aidx : N - 1][k];
            reset_n = !(e.kind == EvA && e.idx == abort_idx);

            @(negedge clk);
            eb  = e.kind inside {EvClear, EvBubW, EvW, EvBubA, EvA, EvDrain};
            ed  = (e.kind == EvDone);
            ewr = e.kind inside {EvBubW, EvW};
            ear = e.kind inside {EvBubA, EvA};
            n_checks++;
            if (busy !== eb) $display("FAIL busy cyc=%0d got=%b exp=%b", c, busy, eb);
            else n_pass++;
            n_checks++;
            if (done !== ed) $display("FAIL done cyc=%0d got=%b exp=%b", c, done, ed);
            else n_pass++;
            n_checks++;
            if (wet_ready !== ewr) $display("FAIL wet_ready cyc=%0d got=%b exp=%b", c, wet_ready, ewr);
            else n_pass++;
            n_checks++;
            if (act_ready !== ear) $display("FAIL act_ready cyc=%0d got=%b exp=%b", c, act_ready, ear);
            else n_pass++;
            n_checks++;
            if (mac !== m_mac) $display("FAIL mac_enable cyc=%0d got=%b exp=%b", c, mac, m_mac);
            else n_pass++;
            n_checks++;
            if (clr !== m_clr) $display("FAIL clear_acc cyc=%0d got=%b exp=%b", c, clr, m_clr);
            else n_pass++;
            n_checks++;
            if (sel !== m_sel) $display("FAIL partial_sel cyc=%0d got=%b exp=%b", c, sel, m_sel);
            else n_pass++;
            n_checks++;
            if (pe_wet !== m_wet) $display("FAIL wet_in cyc=%0d got=%0d exp=%0d", c, pe_wet, m_wet);
            else n_pass++;
            for (int k = 0; k < K; k++) begin
                n_checks++;
                if (pe_act[k] !== m_lane[k])
                    $display("FAIL act_in lane%0d cyc=%0d got=%0d exp=%0d", k, c, pe_act[k], m_lane[k]);
                else n_pass++;
            end

            if (mac && sel) obs_wet_q.push_back(pe_wet);
            if (!mac && obs_wet_q.size() >= 1 && obs_wet_q.size() < K) obs_load_off++;
            if (mac && !sel) begin
                if (obs_adv == 0) obs_lane0_first = pe_act[0];
                for (int k = 0; k < K; k++)
                    if (obs_first_one[k] < 0 && pe_act[k] == 1) obs_first_one[k] = obs_adv;
                obs_adv++;
                obs_last_lane = pe_act[K-1];
            end
            if (done) begin
                obs_done_cnt++;
                obs_done_cyc = c;
            end

            @(posedge clk);
            #1;
            if (!reset_n) begin
                model_reset();
                break;
            end
            case (e.kind)
                EvClear: begin m_mac = 1'b0; m_clr = 1'b1; end
                EvW: begin
                    m_mac = 1'b1; m_clr = 1'b0; m_sel = 1'b1; m_wet = wts[e.idx];
                    widx++;
                end
                EvA, EvDrain: begin
                    m_mac = 1'b1; m_clr = 1'b0; m_sel = 1'b0; m_wet = '0;
                    for (int k = 0; k < K; k++) m_lane[k] = lane_val(e.idx, k);
                    if (e.kind == EvA) aidx++;
                end
                default: begin m_mac = 1'b0; m_clr = 1'b0; end
            endcase
        end
        reset_n = 1'b1;
        start   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; wet_valid = 1'b1; act_valid = 1'b1;
        wet_data = 8'sd55;
        for (int k = 0; k < K; k++) act_data[k] = 8'sd33;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, done, wet_ready, act_ready, mac, clr, sel} !== 7'b0)
            $display("FAIL reset_ctrl got=%b exp=0", {busy, done, wet_ready, act_ready, mac, clr, sel});
        else n_pass++;
        n_checks++;
        if (pe_wet !== 8'sd0) $display("FAIL reset_wet got=%0d exp=0", pe_wet);
        else n_pass++;
        for (int k = 0; k < K; k++) begin
            n_checks++;
            if (pe_act[k] !== 8'sd0) $display("FAIL reset_lane%0d got=%0d exp=0", k, pe_act[k]);
            else n_pass++;
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_tile();
        gen_data(0);
        drive_tile(1'b0, -1);
        n_checks++;
        if (obs_done_cnt != 1) $display("FAIL basic_done_cnt got=%0d exp=1", obs_done_cnt);
        else n_pass++;
        n_checks++;
        if (obs_done_cyc != 2 + K + N + D)
            $display("FAIL basic_latency got=%0d exp=%0d", obs_done_cyc, 2 + K + N + D);
        else n_pass++;
        n_checks++;
        if (obs_wet_q.size() != K) $display("FAIL basic_wbeats got=%0d exp=%0d", obs_wet_q.size(), K);
        else n_pass++;
    endtask

    task automatic test_weight_gaps();
        gen_data(1);
        wgap[2] = 2;
        wgap[4] = 2;
        drive_tile(1'b0, -1);
        n_checks++;
        if (obs_load_off != 4) $display("FAIL wgap_bubbles got=%0d exp=4", obs_load_off);
        else n_pass++;
        for (int i = 0; i < K; i++) begin
            n_checks++;
            if (i >= obs_wet_q.size() || obs_wet_q[i] != i + 1)
                $display("FAIL wgap_seq%0d got=%0d exp=%0d", i,
                         (i < obs_wet_q.size()) ? int'(obs_wet_q[i]) : -999, i + 1);
            else n_pass++;
        end
        n_checks++;
        if (obs_done_cyc != 2 + K + 4 + N + D)
            $display("FAIL wgap_latency got=%0d exp=%0d", obs_done_cyc, 2 + K + 4 + N + D);
        else n_pass++;
    endtask

    task automatic test_stream_ramp(input bit toggle);
        gen_data(1);
        if (toggle) for (int i = 1; i < N; i++) agap[i] = 1;
        drive_tile(1'b0, -1);
        for (int k = 0; k < K; k++) begin
            n_checks++;
            if (obs_first_one[k] != ((SKEW != 0) ? k : 0))
                $display("FAIL ramp_first_one lane%0d got=%0d exp=%0d", k, obs_first_one[k],
                         (SKEW != 0) ? k : 0);
            else n_pass++;
        end
        n_checks++;
        if (obs_last_lane != N) $display("FAIL ramp_last_lane got=%0d exp=%0d", obs_last_lane, N);
        else n_pass++;
        n_checks++;
        if (obs_adv != N + D) $display("FAIL ramp_advances got=%0d exp=%0d", obs_adv, N + D);
        else n_pass++;
    endtask

    task automatic test_random_gaps();
        int extra;
        gen_data(0);
        extra = 0;
        for (int k = 0; k < K; k++) begin wgap[k] = $urandom_range(0, 2); extra += wgap[k]; end
        for (int i = 0; i < N; i++) begin agap[i] = $urandom_range(0, 2); extra += agap[i]; end
        drive_tile(1'b0, -1);
        n_checks++;
        if (obs_done_cyc != 2 + K + N + D + extra)
            $display("FAIL rgap_latency got=%0d exp=%0d", obs_done_cyc, 2 + K + N + D + extra);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int seen_done;
        gen_data(0);
        drive_tile(1'b0, 6);
        seen_done = obs_done_cnt;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) seen_done++;
            n_checks++;
            if ({busy, wet_ready, act_ready, mac, clr, sel} !== 6'b0 || pe_wet !== 8'sd0)
                $display("FAIL abort_outputs cyc=%0d got=%b/%0d exp=0", c,
                         {busy, wet_ready, act_ready, mac, clr, sel}, pe_wet);
            else n_pass++;
            for (int k = 0; k < K; k++) begin
                n_checks++;
                if (pe_act[k] !== 8'sd0) $display("FAIL abort_lane%0d got=%0d exp=0", k, pe_act[k]);
                else n_pass++;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (seen_done != 0) $display("FAIL abort_no_done got=%0d exp=0", seen_done);
        else n_pass++;
        test_basic_tile();
    endtask

    task automatic test_start_held();
        gen_data(2);
        drive_tile(1'b1, -1);
        n_checks++;
        if (obs_done_cnt != 1) $display("FAIL held_done_cnt got=%0d exp=1", obs_done_cnt);
        else n_pass++;
        n_checks++;
        if (obs_lane0_first !== -8'sd128) $display("FAIL held_extreme got=%0d exp=-128", obs_lane0_first);
        else n_pass++;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) $display("FAIL held_rerun got=%b exp=0", busy);
            else n_pass++;
            @(posedge clk);
            #1;
        end
        gen_data(2);
        drive_tile(1'b0, -1);
        n_checks++;
        if (obs_done_cnt != 1) $display("FAIL held_second_tile got=%0d exp=1", obs_done_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 2; t++) begin
            gen_data(0);
            drive_tile(1'b0, -1);
            n_checks++;
            if (obs_done_cnt != 1) $display("FAIL b2b_done tile%0d got=%0d exp=1", t, obs_done_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic_tile();
        test_weight_gaps();
        test_stream_ramp(1'b0);
        test_stream_ramp(1'b1);
        test_random_gaps();
        test_random_gaps();
        test_reset_abort();
        test_start_held();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
